// File: rtl/secuenciador_mem.sv
// Vector load/store sequencer: splits one vector memory op into per-lane data-memory
// accesses and stalls the pipeline until the whole vector has been transferred.
module secuenciador_mem #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                opcode_in,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    input  logic [LANES*DATA_W-1:0]   wdata_vec,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [LANES*DATA_W-1:0]   rdata_vec,
    output logic                      stall,
    output logic                      done,
    output logic                      busy
);

    // state  | meaning
    // IDLE   | waiting for an accepted vector load/store
    // ACCESS | one data-memory access per lane, waits on mem_ack
    // DONE   | one-cycle completion pulse, pipeline released
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;

    state_t                    r_state;
    state_t                    w_next;
    logic [LANE_W-1:0]         r_lane;
    logic [ADDR_W-1:0]         r_addr;
    logic [ADDR_W-1:0]         r_stride;
    logic [LANES*DATA_W-1:0]   r_wdata;
    logic [LANES*DATA_W-1:0]   r_rdata;
    logic                      r_store;
    logic                      w_accept;
    logic                      w_last;

    assign w_accept  = (r_state == S_IDLE) && start &&
                       ((opcode_in == OP_LOAD) || (opcode_in == OP_STORE));
    assign w_last    = (r_lane == LANE_W'(LANES - 1));
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata[r_lane*DATA_W +: DATA_W];
    assign rdata_vec = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        mem_wr  = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // stall already in the start cycle so the MEM register freezes with the op
                if (w_accept) begin
                    stall  = 1'b1;
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_req = 1'b1;
                mem_wr  = r_store;
                stall   = 1'b1;
                if (mem_ack && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane   <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_store  <= 1'b0;
        end else if (w_accept) begin
            r_lane   <= '0;
            r_addr   <= base_addr;
            r_stride <= stride;
            r_wdata  <= wdata_vec;
            r_store  <= (opcode_in == OP_STORE);
            if (opcode_in == OP_LOAD) begin
                r_rdata <= '0;
            end
        end else if ((r_state == S_ACCESS) && mem_ack) begin
            if (!r_store) begin
                r_rdata[r_lane*DATA_W +: DATA_W] <= mem_rdata;
            end
            // address wraps modulo 2^ADDR_W by plain overflow
            if (!w_last) begin
                r_lane <= r_lane + LANE_W'(1);
                r_addr <= r_addr + r_stride;
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_mem.sv
// Self-checking bench for secuenciador_mem: directed and random vector ops against
// a lane-by-lane memory model.
module tb_secuenciador_mem;

    localparam int LANES  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        opcode_in;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [VW-1:0]     wdata_vec;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [VW-1:0]     rdata_vec;
    logic              stall;
    logic              done;
    logic              busy;

    logic [DATA_W-1:0] tb_mem [256];
    logic [VW-1:0]     exp_rdata;
    int                n_assert = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];

    secuenciador_mem #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode_in(opcode_in),
        .base_addr(base_addr), .stride(stride), .wdata_vec(wdata_vec),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata_vec(rdata_vec),
        .stall(stall), .done(done), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start     = 1'b0;
            opcode_in = 4'($urandom_range(0, 15));
            mem_ack   = 1'($urandom_range(0, 1));
            #1;
            check("idle_busy",  busy,      0);
            check("idle_stall", stall,     0);
            check("idle_req",   mem_req,   0);
            check("idle_done",  done,      0);
            check("idle_rdata", rdata_vec, exp_rdata);
        end
    endtask

    // wait_lane >= LANES: no waits; wait_lane < 0: random waits on every lane
    task automatic run_vec(input logic [3:0] op, input logic [7:0] base, input logic [7:0] strd,
                           input logic [VW-1:0] wd, input int wait_lane, input int wait_n,
                           input bit spam, input int abort_lane);
        bit              accept;
        bit              is_store;
        logic [7:0]      addr;
        int              waits;
        accept   = (op == 4'b0011) || (op == 4'b0100);
        is_store = (op == 4'b0100);
        @(negedge clk);
        start = 1'b1; opcode_in = op; base_addr = base; stride = strd; wdata_vec = wd;
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        check("start_stall", stall,     accept);
        check("start_busy",  busy,      0);
        check("start_req",   mem_req,   0);
        check("start_rdata", rdata_vec, exp_rdata);
        if (!accept) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check("rej_busy",  busy,    0);
            check("rej_stall", stall,   0);
            check("rej_req",   mem_req, 0);
            return;
        end
        if (!is_store) exp_rdata = '0;
        addr = base;
        for (int lane = 0; lane < LANES; lane++) begin
            if (lane == wait_lane) waits = wait_n;
            else if (wait_lane < 0) waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            else waits = 0;
            for (int c = 0; c <= waits; c++) begin
                @(negedge clk);
                start     = spam;
                opcode_in = ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b0100;
                base_addr = 8'($urandom);
                stride    = 8'($urandom);
                wdata_vec = VW'($urandom);
                mem_ack   = (c == waits);
                #1;
                if (lane == abort_lane) begin
                    start = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check("rst_req",   mem_req,   0);
                    check("rst_wr",    mem_wr,    0);
                    check("rst_addr",  mem_addr,  0);
                    check("rst_wdata", mem_wdata, 0);
                    check("rst_rdata", rdata_vec, 0);
                    check("rst_done",  done,      0);
                    check("rst_busy",  busy,      0);
                    check("rst_stall", stall,     0);
                    exp_rdata = '0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                check("acc_req",   mem_req,   1);
                check("acc_wr",    mem_wr,    is_store);
                check("acc_addr",  mem_addr,  addr);
                if (is_store) check("acc_wdata", mem_wdata, wd[lane*DATA_W +: DATA_W]);
                check("acc_stall", stall,     1);
                check("acc_busy",  busy,      1);
                check("acc_done",  done,      0);
                if (c == waits) begin
                    if (is_store) tb_mem[addr] = wd[lane*DATA_W +: DATA_W];
                    else exp_rdata[lane*DATA_W +: DATA_W] = tb_mem[addr];
                    addr = addr + strd;
                end
            end
        end
        @(negedge clk);
        start     = spam;
        opcode_in = 4'b0011;
        mem_ack   = 1'($urandom_range(0, 1));
        #1;
        check("done_pulse", done,      1);
        check("done_req",   mem_req,   0);
        check("done_stall", stall,     0);
        check("done_busy",  busy,      1);
        check("done_rdata", rdata_vec, exp_rdata);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) tb_mem[a] = 8'(a + 8'h80);
        exp_rdata = '0;
        rst_n = 1'b0; start = 1'b0; opcode_in = '0; base_addr = '0; stride = '0;
        wdata_vec = '0; mem_ack = 1'b0;
        #12;
        check("reset_req",   mem_req,   0);
        check("reset_addr",  mem_addr,  0);
        check("reset_rdata", rdata_vec, 0);
        check("reset_busy",  busy,      0);
        check("reset_stall", stall,     0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        run_vec(4'b0011, 8'h10, 8'h01, '0, LANES, 0, 1'b0, -1);
        idle(1);
        check("tp_load_vec", rdata_vec, 32'h93929190);

        run_vec(4'b0100, 8'hF8, 8'h04, 32'hDDCCBBAA, LANES, 0, 1'b0, -1);
        idle(1);
        check("tp_store_keep", rdata_vec, 32'h93929190);

        run_vec(4'b0011, 8'h20, 8'h03, '0, 1, 2, 1'b0, -1);
        idle(1);

        run_vec(4'b0011, 8'($urandom), 8'($urandom), '0, LANES, 0, 1'b1, -1);
        run_vec(4'b0100, 8'($urandom), 8'($urandom), VW'($urandom), LANES, 0, 1'b0, -1);
        idle(1);

        run_vec(4'b0001, 8'h30, 8'h01, '0, LANES, 0, 1'b0, -1);
        run_vec(4'b1111, 8'h30, 8'h01, '0, LANES, 0, 1'b0, -1);

        run_vec(4'b0011, 8'h40, 8'h02, '0, LANES, 0, 1'b0, 2);
        idle(3);
        run_vec(4'b0011, 8'h40, 8'h02, '0, LANES, 0, 1'b0, -1);
        idle(1);

        for (int t = 0; t < 25; t++) begin
            logic [3:0] op;
            case ($urandom_range(0, 4))
                0, 1:    op = 4'b0011;
                2, 3:    op = 4'b0100;
                default: op = 4'($urandom_range(0, 15));
            endcase
            run_vec(op, 8'($urandom), 8'($urandom), VW'($urandom), -1, 0,
                    1'($urandom_range(0, 1)), -1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/secuenciador_mem.md
# secuenciador_mem

Multi-cycle vector memory sequencer for the vector processor's memory stage. When the control path issues a vector load (opcode 0011) or vector store (opcode 0100), it breaks the vector into one data-memory access per lane. It walks a base address plus stride, handshakes each access with the data memory, and stalls the pipeline until the whole vector has been transferred. It sits between the EXE/MEM pipeline register and the data memory, in parallel with the scalar memory path.

## Interface
- LANES, 4, elements per vector register (≥2)
- ADDR_W, 8, data-memory address width
- DATA_W, 8, element width
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request from MEM stage; sampled only in IDLE
- opcode_in  in  4  opcode accompanying start; only 0011 (load) and 0100 (store) are accepted
- base_addr  in  ADDR_W  address of lane 0, sampled with start
- stride  in  ADDR_W  address increment between lanes, sampled with start
- wdata_vec  in  LANES*DATA_W  store data; lane i is bits [i*DATA_W +: DATA_W]; sampled with start
- mem_req  out  1  access request to data memory
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store element for current lane
- mem_ack  in  1  access completed this cycle; may be asserted combinationally in the same cycle as mem_req
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1 on a read
- rdata_vec  out  LANES*DATA_W  assembled load vector, same lane packing as wdata_vec
- stall  out  1  freeze fetch/decode/EXE and the MEM pipeline register
- done  out  1  one-cycle pulse when the vector transfer is complete
- busy  out  1  sequencer not in IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE → ACCESS on start=1 with opcode_in ∈ {0011, 0100}:
  - latch base_addr, stride, wdata_vec and the op type (load/store);
  - clear lane counter i to 0; clear rdata_vec on load.
- start with any other opcode: ignored; no stall, stays IDLE.
- ACCESS:
  - mem_req=1, mem_wr=(op==store), mem_addr=base+i*stride, mem_wdata=lane i of latched wdata.
  - Address is held by an accumulator: it starts at base and adds stride per acked lane, modulo 2^ADDR_W (wraps silently).
  - mem_ack=0: hold all outputs, stay in ACCESS (wait state, unbounded).
  - mem_ack=1 on a load: write mem_rdata into lane i of rdata_vec. Store: no data capture.
  - mem_ack=1 with i<LANES-1: i++, address += stride.
  - mem_ack=1 with i==LANES-1: go to DONE.
- DONE: done=1, mem_req=0; rdata_vec holds the final vector; unconditionally go to IDLE next cycle.
- rdata_vec holds its value in IDLE until the next accepted load; a store does not modify it.
- start in ACCESS or DONE: ignored (no queueing).
- mem_ack while mem_req=0: ignored.
- busy=1 in ACCESS and DONE.

## Timing
- stall is combinational: 1 in ACCESS, and in IDLE when an accepted start is present. Otherwise 0, including in DONE.
  - The pipeline freezes in the start cycle itself and releases in the DONE cycle.
- Zero-wait memory (mem_ack=1 whenever requested): start at cycle T; ACCESS for lanes 0..LANES-1 at T+1..T+LANES; done at T+LANES+1.
  - stall is high for cycles T..T+LANES (LANES+1 cycles).
- Each wait cycle (mem_ack=0) adds one cycle to the stall.
- Back-to-back: start is accepted no earlier than the IDLE cycle after DONE, i.e. T+LANES+2 at the earliest.
- Reset (asynchronous, any state, including mid-vector):
  - state=IDLE, i=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata_vec=0, done=0, busy=0, stall=0;
  - all latched operands cleared.
  - An interrupted store may have written a prefix of lanes; no rollback.

## Test plan
- Load, LANES=4, base=0x10, stride=1, ack always 1, memory returns addr+0x80 → reads at 0x10,0x11,0x12,0x13 in T+1..T+4; done at T+5; rdata_vec=0x93929190; stall high T..T+4.
- Store, base=0xF8, stride=4, wdata_vec=0xDDCCBBAA → writes AA@F8, BB@FC, CC@00, DD@04 (wrap); mem_wr=1 on all four; rdata_vec unchanged.
- Load with mem_ack held low 2 cycles on lane 1 → mem_addr and mem_req hold for 3 cycles on lane 1; done at T+7; data correct.
- start repeated during ACCESS and in the DONE cycle → ignored; exactly 4 accesses; next start accepted in the following IDLE cycle.
- start with opcode_in=0001 → no stall, no mem_req, busy stays 0.
- rst_n low during lane 2 of a load → all outputs reset immediately; after release, stays IDLE until the next start; a new load completes normally.
